load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side controller for the word-addressed data memory: accepts load/store requests from the core over a valid/ready handshake and issues word-aligned read and write cycles to the memory. Byte stores are done as read-modify-write, byte loads by lane extraction, and misaligned or out-of-range accesses are rejected. It sits between the datapath's memory stage and the data memory, which has a combinational read and a write on the rising clock edge.

## Interface
- MEM_WORDS, 64, number of 32-bit words in the attached memory; word indices at or above this value are out of range
- clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = word access
- req_addr  in  32  byte address
- req_wdata  in  32  store data; a byte store uses bits [7:0]
- resp_valid  out  1  response available
- resp_ready  in  1  core accepts the response
- resp_rdata  out  32  load data; a byte load is zero-extended; 0 for stores and errors
- resp_err  out  1  access was rejected
- mem_addr  out  32  byte address to memory, bits [1:0] always 0
- mem_we  out  1  memory write enable
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, combinational from mem_addr

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE
  - req_ready=1.
  - A request is accepted when req_valid&&req_ready. On accept, store/byte/addr/wdata are captured in registers.
  - Next state on accept:
    - error -> RESP with err=1;
    - word store -> WRITE;
    - any other access -> READ.
- Error conditions: out-of-range is addr[31:2] >= MEM_WORDS; misaligned is a word access with addr[1:0] != 0. Either one gives resp_err=1, and no memory write occurs.
- READ
  - mem_addr = {addr[31:2],2'b00}; mem_rd is sampled at the end of the cycle.
  - Load: byte load captures mem_rd[8*addr[1:0] +: 8] zero-extended into resp_rdata; word load captures all of mem_rd. Then -> RESP.
  - Byte store: the merged word is formed by replacing lane addr[1:0] of mem_rd with wdata[7:0]; other lanes are unchanged. Then -> WRITE.
- WRITE
  - mem_we=1 for exactly one cycle; mem_wd = merged word (byte store) or wdata (word store). Then -> RESP.
- RESP
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - Stays in RESP until resp_ready, then -> IDLE.
- mem_we = (state==WRITE) && !Reset. A reset asserted during WRITE suppresses the write.
- mem_addr is held at the captured aligned address from accept until return to IDLE. In IDLE it is 0.

## Timing
- Reset values: state IDLE; req_ready=0 while Reset is high and 1 in the first cycle after; resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
- Latency from the accept edge to resp_valid, for zero-cycle resp_ready:
  - word store: 2 cycles (WRITE, RESP);
  - loads: 2 cycles (READ, RESP);
  - byte store: 3 cycles (READ, WRITE, RESP);
  - error: 1 cycle.
- Throughput: at most one request in flight. req_ready is 0 in every state except IDLE, so a back-to-back request is accepted in the cycle after resp_valid&&resp_ready.
- A store's memory update is visible on mem_rd from the cycle after WRITE, so a subsequent load returns the new data.
- resp_valid must not drop and resp_rdata/resp_err must not change until resp_ready is seen.
- Reset mid-operation (any state): at the next edge, return to IDLE and drop resp_valid; the captured request is discarded.

## Structure
- Package lsu_pkg holds:
  - the state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2, RESP=2'd3);
  - the byte-lane width constant (8);
  - the default MEM_WORDS value.
- Sub-module lsu_byte_lane is combinational. Inputs: word, lane, byte. Outputs: extracted zero-extended byte and merged word. It is instantiated once.

## Test plan
- Word store then load: store addr 0x10 data 0xDEADBEEF; mem_we high for 1 cycle with mem_addr 0x10. A following load of 0x10 returns 0xDEADBEEF, resp_err=0.
- Byte store read-modify-write:
  - Preload 0x11223344 at 0x20, then store byte 0xAA to 0x22.
  - mem_wd=0x11AA3344 and resp_valid 3 cycles after accept.
  - A byte load from 0x22 returns 0x000000AA.
- Misaligned word: load or store at 0x06 -> resp_err=1, resp_rdata=0, 1-cycle latency, mem_we never asserted.
- Out of range: with MEM_WORDS=64, a store to 0x100 -> resp_err=1 and memory word 0 is unchanged.
- Response backpressure: hold resp_ready=0 for 5 cycles. resp_valid and resp_rdata stay stable and req_ready stays 0. A second request is accepted only in the cycle after the handshake.
- Reset during WRITE of a byte store to 0x30: Reset high in the WRITE cycle -> mem_we=0 and the memory word is unchanged. The next cycle is IDLE with resp_valid=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StResp  = 2'd3
    } lsu_state_e;

    localparam int unsigned LANE_W        = 8;
    localparam int unsigned MEM_WORDS_DEF = 64;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: extracts one lane of a word (zero-extended) and
// produces the word with that lane replaced by a new byte.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0]       word,
    input  logic [1:0]        lane,
    input  logic [LANE_W-1:0] new_byte,
    output logic [31:0]       extracted,
    output logic [31:0]       merged
);

    always_comb begin
        extracted = '0;
        merged    = word;
        case (lane)
            2'd0: begin
                extracted[LANE_W-1:0]        = word[0*LANE_W +: LANE_W];
                merged[0*LANE_W +: LANE_W]   = new_byte;
            end
            2'd1: begin
                extracted[LANE_W-1:0]        = word[1*LANE_W +: LANE_W];
                merged[1*LANE_W +: LANE_W]   = new_byte;
            end
            2'd2: begin
                extracted[LANE_W-1:0]        = word[2*LANE_W +: LANE_W];
                merged[2*LANE_W +: LANE_W]   = new_byte;
            end
            default: begin
                extracted[LANE_W-1:0]        = word[3*LANE_W +: LANE_W];
                merged[3*LANE_W +: LANE_W]   = new_byte;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, word-aligned memory cycles,
// byte stores by read-modify-write, byte loads by lane extraction.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state_q, state_d;

    logic        store_q, byte_q, err_q;
    logic [31:0] addr_q, wdata_q, merged_q, rdata_q;

    logic        accept, req_err, misaligned, out_of_range;
    logic [31:0] lane_byte, lane_merged;

    assign out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    assign misaligned   = !req_byte && (req_addr[1:0] != 2'b00);
    assign req_err      = out_of_range || misaligned;
    assign accept       = req_valid && req_ready;

    lsu_byte_lane u_byte_lane (
        .word      (mem_rd),
        .lane      (addr_q[1:0]),
        .new_byte  (wdata_q[LANE_W-1:0]),
        .extracted (lane_byte),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_store && !req_byte) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            // Only byte stores reach READ as stores.
            StRead:  state_d = store_q ? StWrite : StResp;
            StWrite: state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle) && !Reset;
        resp_valid = (state_q == StResp);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_we     = (state_q == StWrite) && !Reset;
        mem_addr   = (state_q == StIdle) ? 32'd0 : {addr_q[31:2], 2'b00};
        mem_wd     = (state_q == StWrite) ? (byte_q ? merged_q : wdata_q) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            store_q  <= 1'b0;
            byte_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else if (accept) begin
            store_q  <= req_store;
            byte_q   <= req_byte;
            err_q    <= req_err;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
        end else if (state_q == StRead) begin
            if (store_q) begin
                merged_q <= lane_merged;
            end else begin
                rdata_q  <= byte_q ? lane_byte : mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        Reset;
    logic        req_valid, req_ready, req_store, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [0:63];

    assign mem_rd = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
    end

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          lat, we_cnt;
    logic [31:0] we_addr, we_wd, r_data;
    logic        r_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; counts edges until resp_valid.
    task automatic wait_resp();
        lat     = 1;
        we_cnt  = 0;
        we_addr = '0;
        we_wd   = '0;
        while (!resp_valid && lat < 10) begin
            if (mem_we) begin
                we_cnt++;
                we_addr = mem_addr;
                we_wd   = mem_wd;
            end
            step();
            lat++;
        end
        check_eq("resp_valid_seen", 32'(resp_valid), 32'd1);
        r_data = resp_rdata;
        r_err  = resp_err;
    endtask

    task automatic xact(input logic st, input logic by, input logic [31:0] a,
                        input logic [31:0] wd);
        req_valid = 1'b1;
        req_store = st;
        req_byte  = by;
        req_addr  = a;
        req_wdata = wd;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        wait_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        Reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_byte   = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        step();
        check_eq("req_ready_in_reset", 32'(req_ready), 32'd0);
        step();
        Reset = 1'b0;
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_resp_err", 32'(resp_err), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wd", mem_wd, 32'd0);

        // Word store then load
        xact(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        check_eq("wst_lat", lat, 32'd2);
        check_eq("wst_we_cnt", we_cnt, 32'd1);
        check_eq("wst_we_addr", we_addr, 32'h10);
        check_eq("wst_we_wd", we_wd, 32'hDEADBEEF);
        check_eq("wst_err", 32'(r_err), 32'd0);
        check_eq("wst_rdata", r_data, 32'd0);
        check_eq("wst_mem", mem[4], 32'hDEADBEEF);
        xact(1'b0, 1'b0, 32'h10, 32'h0);
        check_eq("wld_lat", lat, 32'd2);
        check_eq("wld_rdata", r_data, 32'hDEADBEEF);
        check_eq("wld_err", 32'(r_err), 32'd0);

        // Byte store read-modify-write
        xact(1'b1, 1'b0, 32'h20, 32'h11223344);
        xact(1'b1, 1'b1, 32'h22, 32'h123456AA);
        check_eq("bst_lat", lat, 32'd3);
        check_eq("bst_we_cnt", we_cnt, 32'd1);
        check_eq("bst_we_addr", we_addr, 32'h20);
        check_eq("bst_we_wd", we_wd, 32'h11AA3344);
        check_eq("bst_mem", mem[8], 32'h11AA3344);
        xact(1'b0, 1'b1, 32'h22, 32'h0);
        check_eq("bld22_lat", lat, 32'd2);
        check_eq("bld22_rdata", r_data, 32'h000000AA);
        xact(1'b0, 1'b1, 32'h23, 32'h0);
        check_eq("bld23_rdata", r_data, 32'h00000011);
        xact(1'b0, 1'b1, 32'h20, 32'h0);
        check_eq("bld20_rdata", r_data, 32'h00000044);

        // Misaligned word accesses
        xact(1'b0, 1'b0, 32'h06, 32'h0);
        check_eq("misld_lat", lat, 32'd1);
        check_eq("misld_err", 32'(r_err), 32'd1);
        check_eq("misld_rdata", r_data, 32'd0);
        xact(1'b1, 1'b0, 32'h06, 32'hFFFFFFFF);
        check_eq("misst_lat", lat, 32'd1);
        check_eq("misst_err", 32'(r_err), 32'd1);
        check_eq("misst_we_cnt", we_cnt, 32'd0);
        check_eq("misst_mem4", mem[4], 32'hDEADBEEF);

        // Out of range store must not alias onto word 0
        xact(1'b1, 1'b0, 32'h0, 32'h0BADC0DE);
        xact(1'b1, 1'b0, 32'h100, 32'hCAFEF00D);
        check_eq("oor_lat", lat, 32'd1);
        check_eq("oor_err", 32'(r_err), 32'd1);
        check_eq("oor_we_cnt", we_cnt, 32'd0);
        check_eq("oor_mem0", mem[0], 32'h0BADC0DE);
        xact(1'b0, 1'b0, 32'hFC, 32'h0);
        check_eq("last_word_err", 32'(r_err), 32'd0);

        // Response backpressure with a second request waiting
        req_valid = 1'b1;
        req_store = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 32'h10;
        step();
        req_addr = 32'h20;
        wait_resp();
        check_eq("bp_lat", lat, 32'd2);
        check_eq("bp_rdata", r_data, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_hold_valid", 32'(resp_valid), 32'd1);
            check_eq("bp_hold_rdata", resp_rdata, 32'hDEADBEEF);
            check_eq("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check_eq("bp_after_valid", 32'(resp_valid), 32'd0);
        check_eq("bp_after_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check_eq("bp_second_taken", 32'(req_ready), 32'd0);
        wait_resp();
        check_eq("bp_second_rdata", r_data, 32'h11AA3344);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Reset during WRITE of a byte store
        xact(1'b1, 1'b0, 32'h30, 32'h55667788);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_byte  = 1'b1;
        req_addr  = 32'h31;
        req_wdata = 32'h000000EE;
        step();
        req_valid = 1'b0;
        check_eq("rw_mem_addr", mem_addr, 32'h30);
        step();
        Reset = 1'b1;
        #1;
        check_eq("rw_we_masked", 32'(mem_we), 32'd0);
        step();
        Reset = 1'b0;
        #1;
        check_eq("rw_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rw_mem_addr_idle", mem_addr, 32'd0);
        check_eq("rw_mem", mem[12], 32'h55667788);
        xact(1'b0, 1'b1, 32'h31, 32'h0);
        check_eq("rw_bld_rdata", r_data, 32'h00000077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
